// File: rtl/dpi_reg_pkg.sv
// Shared types and constants for the host register-access responder.
// DPI_REG_BYTE_STROBE_EN adds a per-byte write strobe to the captured request.
package dpi_reg_pkg;

    // Index of the free-running cycle counter inside the register bank
    localparam int CNT_IDX = 0;

    // Width of the host-side register index
    localparam int REQ_ADDR_W = 8;

    // Data width the captured request is sized for; the bank DATA_W must match it
    localparam int REQ_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [REQ_DATA_W-1:0]   wdata;
`ifdef DPI_REG_BYTE_STROBE_EN
        logic [REQ_DATA_W/8-1:0] wstrb;
`endif
    } dpi_req_t;

    // True when a host index names a register that actually exists
    function automatic logic addrInRange(input logic [REQ_ADDR_W-1:0] addr, input int numRegs);
        return int'(addr) < numRegs;
    endfunction

endpackage

// File: rtl/dpi_reg_bank.sv
// Register bank behind the host responder: plain registers, read-only
// masking, the free-running cycle counter and the byte-strobe write merge.
// The strobe is always present here; full-word writes simply drive all ones.
module dpi_reg_bank
    import dpi_reg_pkg::*;
#(
    parameter int                  NUM_REGS = 8,
    parameter int                  DATA_W   = 64,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 'h1,
    localparam int                 ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wrEn_i,
    input  logic [ADDR_W-1:0]          wrAddr_i,
    input  logic [DATA_W-1:0]          wrData_i,
    input  logic [DATA_W/8-1:0]        wrStrb_i,
    input  logic [ADDR_W-1:0]          rdAddr_i,
    output logic [DATA_W-1:0]          rdData_o,
    output logic [NUM_REGS*DATA_W-1:0] regsFlat_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next bank contents: counter always advances, one writable register may take merged bytes
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (i == CNT_IDX) begin
                regs_d[i] = regs_q[i] + DATA_W'(1);
            end else if (wrEn_i && !RO_MASK[i] && int'(wrAddr_i) == i) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (wrStrb_i[b]) begin
                        regs_d[i][b*8 +: 8] = wrData_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Bank state, cleared to zero (counter included) by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdData_o = regs_q[rdAddr_i];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regsFlat_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: rtl/dpi_reg_responder.sv
// Hardware end of the host register-access path: takes one read/write
// command at a time, applies it to the bank and returns data plus an error flag.
// DPI_REG_BYTE_STROBE_EN adds the req_wstrb input for partial-word writes.
module dpi_reg_responder
    import dpi_reg_pkg::*;
#(
    parameter int                  NUM_REGS = 8,
    parameter int                  DATA_W   = REQ_DATA_W,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 'h1,
    localparam int                 ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [REQ_ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
`ifdef DPI_REG_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0]        req_wstrb,
`endif
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

    state_e              state_q;
    dpi_req_t            req_q;
    dpi_req_t            reqIn;
    logic                reqReady_q;
    logic                respValid_q;
    logic [DATA_W-1:0]   respRdata_q;
    logic                respErr_q;

    logic                inRange;
    logic                roHit;
    logic                accessErr;
    logic                bankWrEn;
    logic [ADDR_W-1:0]   bankAddr;
    logic [DATA_W-1:0]   bankRdData;
    logic [DATA_W/8-1:0] capWstrb;

    // Pack the live request pins into the form held for the access cycle
    always_comb begin
        reqIn       = '0;
        reqIn.write = req_write;
        reqIn.addr  = req_addr;
        reqIn.wdata[DATA_W-1:0] = req_wdata;
`ifdef DPI_REG_BYTE_STROBE_EN
        reqIn.wstrb[DATA_W/8-1:0] = req_wstrb;
`endif
    end

`ifdef DPI_REG_BYTE_STROBE_EN
    assign capWstrb = req_q.wstrb[DATA_W/8-1:0];
`else
    assign capWstrb = '1;
`endif

    // The counter is never writable, even if the mask forgot to say so
    assign inRange   = addrInRange(req_q.addr, NUM_REGS);
    assign bankAddr  = req_q.addr[ADDR_W-1:0];
    assign roHit     = RO_MASK[bankAddr] || (int'(bankAddr) == CNT_IDX);
    assign accessErr = !inRange || (req_q.write && roHit);
    assign bankWrEn  = (state_q == ST_ACCESS) && req_q.write && !accessErr;

    dpi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .clock      (clock),
        .reset      (reset),
        .wrEn_i     (bankWrEn),
        .wrAddr_i   (bankAddr),
        .wrData_i   (req_q.wdata[DATA_W-1:0]),
        .wrStrb_i   (capWstrb),
        .rdAddr_i   (bankAddr),
        .rdData_o   (bankRdData),
        .regsFlat_o (regs_flat)
    );

    // Command FSM: capture in IDLE, decode and load the response in ACCESS, hold it in RESP
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && reqReady_q) begin
                        req_q      <= reqIn;
                        reqReady_q <= 1'b0;
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    respValid_q <= 1'b1;
                    respErr_q   <= accessErr;
                    respRdata_q <= (accessErr || req_q.write) ? '0 : bankRdData;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        respRdata_q <= '0;
                        respErr_q   <= 1'b0;
                        reqReady_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = reqReady_q;
    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;

endmodule
